// File: rtl/alloc_dispatch_controller_if.sv
// Allocation handshake bundle between the dispatch controller, the inflight
// WG buffer, the allocator and the global resource table.
//   master : dispatch controller side (drives dis_controller_* signals)
//   slave  : environment side (buffer, allocator, GRT)
interface alloc_dispatch_controller_if #(
  parameter int NUMBER_CU   = 4,
  parameter int CU_ID_WIDTH = 2
);
  logic                   inflight_wg_buffer_alloc_valid;
  logic                   dis_controller_start_alloc;
  logic                   allocator_cu_valid;
  logic                   allocator_cu_rejected;
  logic [CU_ID_WIDTH-1:0] allocator_cu_id_out;
  logic                   dis_controller_alloc_ack;
  logic                   dis_controller_wg_alloc_valid;
  logic                   dis_controller_wg_rejected_valid;
  logic [CU_ID_WIDTH-1:0] dis_controller_alloc_cu_id;
  logic [NUMBER_CU-1:0]   dis_controller_cu_busy;
  logic                   grt_cam_up_valid;
  logic [CU_ID_WIDTH-1:0] grt_cam_up_cu_id;

  modport master (
    input  inflight_wg_buffer_alloc_valid,
    input  allocator_cu_valid,
    input  allocator_cu_rejected,
    input  allocator_cu_id_out,
    input  grt_cam_up_valid,
    input  grt_cam_up_cu_id,
    output dis_controller_start_alloc,
    output dis_controller_alloc_ack,
    output dis_controller_wg_alloc_valid,
    output dis_controller_wg_rejected_valid,
    output dis_controller_alloc_cu_id,
    output dis_controller_cu_busy
  );

  modport slave (
    output inflight_wg_buffer_alloc_valid,
    output allocator_cu_valid,
    output allocator_cu_rejected,
    output allocator_cu_id_out,
    output grt_cam_up_valid,
    output grt_cam_up_cu_id,
    input  dis_controller_start_alloc,
    input  dis_controller_alloc_ack,
    input  dis_controller_wg_alloc_valid,
    input  dis_controller_wg_rejected_valid,
    input  dis_controller_alloc_cu_id,
    input  dis_controller_cu_busy
  );
endinterface

// File: rtl/alloc_dispatch_controller.sv
// Dispatcher-side initiator of the WG allocation handshake: pulses start to
// the allocator, acknowledges its accept/reject verdict, keeps the per-CU
// busy mask and a retry holdoff after rejections.
//   clk, rst : clock, synchronous active-high reset
//   bus      : handshake bundle (master modport), all outputs registered
module alloc_dispatch_controller #(
  parameter int NUMBER_CU       = 4,
  parameter int CU_ID_WIDTH     = 2,
  parameter int RETRY_DELAY     = 16,
  parameter int RETRY_CNT_WIDTH = 5
) (
  input logic                     clk,
  input logic                     rst,
  alloc_dispatch_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC_WAIT,
    S_ACK_OK,
    S_ACK_REJ,
    S_SETTLE
  } state_t;

  state_t                     state_q, state_d;
  logic                       start_q, start_d;
  logic                       ack_q, ack_d;
  logic                       commit_q, commit_d;
  logic                       reject_q, reject_d;
  logic [CU_ID_WIDTH-1:0]     cu_id_q, cu_id_d;
  logic [NUMBER_CU-1:0]       busy_q, busy_d;
  logic [RETRY_CNT_WIDTH-1:0] holdoff_q, holdoff_d;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    ack_d     = 1'b0;
    commit_d  = 1'b0;
    reject_d  = 1'b0;
    cu_id_d   = cu_id_q;
    busy_d    = busy_q;
    holdoff_d = holdoff_q;

    if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 1'b1;
    end

    // Clears are applied before the FSM so a same-cycle set or load overrides them.
    if (bus.grt_cam_up_valid) begin
      holdoff_d = '0;
      for (int unsigned i = 0; i < NUMBER_CU; i++) begin
        if (bus.grt_cam_up_cu_id == CU_ID_WIDTH'(i)) begin
          busy_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.inflight_wg_buffer_alloc_valid && !(&busy_q) && holdoff_q == '0) begin
          state_d = S_ALLOC_WAIT;
          start_d = 1'b1;
        end
      end
      S_ALLOC_WAIT: begin
        if (bus.allocator_cu_valid) begin
          for (int unsigned i = 0; i < NUMBER_CU; i++) begin
            if (bus.allocator_cu_id_out == CU_ID_WIDTH'(i)) begin
              busy_d[i] = 1'b1;
            end
          end
          cu_id_d  = bus.allocator_cu_id_out;
          ack_d    = 1'b1;
          commit_d = 1'b1;
          state_d  = S_ACK_OK;
        end else if (bus.allocator_cu_rejected) begin
          ack_d    = 1'b1;
          reject_d = 1'b1;
          state_d  = S_ACK_REJ;
        end
      end
      S_ACK_OK: begin
        state_d = S_SETTLE;
      end
      S_ACK_REJ: begin
        holdoff_d = RETRY_CNT_WIDTH'(RETRY_DELAY);
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      commit_q  <= 1'b0;
      reject_q  <= 1'b0;
      cu_id_q   <= '0;
      busy_q    <= '0;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      commit_q  <= commit_d;
      reject_q  <= reject_d;
      cu_id_q   <= cu_id_d;
      busy_q    <= busy_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign bus.dis_controller_start_alloc       = start_q;
  assign bus.dis_controller_alloc_ack         = ack_q;
  assign bus.dis_controller_wg_alloc_valid    = commit_q;
  assign bus.dis_controller_wg_rejected_valid = reject_q;
  assign bus.dis_controller_alloc_cu_id       = cu_id_q;
  assign bus.dis_controller_cu_busy           = busy_q;

endmodule

// File: tb/tb_alloc_dispatch_controller.sv
module tb_alloc_dispatch_controller;
  localparam int NCU = 4;
  localparam int IDW = 2;
  localparam int RD  = 16;
  localparam int RCW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alloc_dispatch_controller_if #(.NUMBER_CU(NCU), .CU_ID_WIDTH(IDW)) bus_if ();

  alloc_dispatch_controller #(
    .NUMBER_CU(NCU), .CU_ID_WIDTH(IDW), .RETRY_DELAY(RD), .RETRY_CNT_WIDTH(RCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---------------- reference model (timestamp based) ----------------
  bit       exp_valid = 0;
  bit       m_txn;          // start issued, verdict not yet taken
  int       m_vat = -100;   // cycle the last verdict was taken
  bit       m_ok;
  int       m_hold;
  bit       m_busy [NCU];
  bit       e_start, e_ack, e_com, e_rej;
  int       e_id;
  logic [NCU-1:0] e_busy;

  task automatic model_step();
    bit idle, full, rej_ack_now, n_start;
    if (rst) begin
      m_txn = 0; m_vat = -100; m_ok = 0; m_hold = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      e_start = 0; e_ack = 0; e_com = 0; e_rej = 0; e_id = 0;
      exp_valid = 1;
    end else begin
      idle = !m_txn && (cyc >= m_vat + 3);
      full = 1;
      foreach (m_busy[i]) if (!m_busy[i]) full = 0;
      rej_ack_now = (cyc == m_vat + 1) && !m_ok;
      n_start = idle && bus_if.inflight_wg_buffer_alloc_valid && !full && (m_hold == 0);
      e_start = n_start; e_ack = 0; e_com = 0; e_rej = 0;
      if (rej_ack_now) m_hold = RD;
      else if (bus_if.grt_cam_up_valid) m_hold = 0;
      else if (m_hold > 0) m_hold--;
      if (bus_if.grt_cam_up_valid) m_busy[int'(bus_if.grt_cam_up_cu_id)] = 0;
      if (m_txn && (bus_if.allocator_cu_valid || bus_if.allocator_cu_rejected)) begin
        m_txn = 0;
        m_vat = cyc;
        m_ok  = bus_if.allocator_cu_valid;
        e_ack = 1;
        e_com = m_ok;
        e_rej = !m_ok;
        if (m_ok) begin
          m_busy[int'(bus_if.allocator_cu_id_out)] = 1;
          e_id = int'(bus_if.allocator_cu_id_out);
        end
      end
      if (n_start) m_txn = 1;
    end
    foreach (m_busy[i]) e_busy[i] = m_busy[i];
  endtask

  // ---------------- allocator stand-in ----------------
  bit bfm_en = 0;
  int f_kind = 0;    // 0 random, 1 accept, 2 reject
  int f_id = -1;     // -1 random
  int f_delay = -1;  // -1 random
  bit b_pend, b_acc, b_both;
  int b_cnt, b_id;

  task automatic bfm_clear();
    b_pend = 0;
    bus_if.allocator_cu_valid = 0;
    bus_if.allocator_cu_rejected = 0;
  endtask

  task automatic drive_bfm();
    if (!bfm_en) return;
    if (bus_if.dis_controller_alloc_ack) begin
      bfm_clear();
    end else if (bus_if.dis_controller_start_alloc) begin
      b_pend = 1;
      b_cnt  = (f_delay >= 0) ? f_delay : int'($urandom_range(0, 3));
      b_acc  = (f_kind == 1) || (f_kind == 0 && $urandom_range(0, 9) < 7);
      b_id   = (f_id >= 0) ? f_id : int'($urandom_range(0, NCU - 1));
      b_both = (f_kind == 0) && ($urandom_range(0, 15) == 0);
    end
    if (b_pend) begin
      if (b_cnt == 0) begin
        bus_if.allocator_cu_valid    = b_acc || b_both;
        bus_if.allocator_cu_rejected = !b_acc || b_both;
        bus_if.allocator_cu_id_out   = IDW'(b_id);
      end else begin
        b_cnt--;
      end
    end
    if (!bus_if.allocator_cu_valid) bus_if.allocator_cu_id_out = IDW'($urandom);
  endtask

  // ---------------- cycle engine ----------------
  bit obs_start, obs_ack, obs_com, obs_rej;
  logic [IDW-1:0] obs_id;
  logic [NCU-1:0] obs_busy;
  int start_count = 0, ack_count = 0;
  int last_start_cyc = -1, last_ack_cyc = -1;

  task automatic run_cycle();
    drive_bfm();
    @(negedge clk);
    obs_start = bus_if.dis_controller_start_alloc;
    obs_ack   = bus_if.dis_controller_alloc_ack;
    obs_com   = bus_if.dis_controller_wg_alloc_valid;
    obs_rej   = bus_if.dis_controller_wg_rejected_valid;
    obs_id    = bus_if.dis_controller_alloc_cu_id;
    obs_busy  = bus_if.dis_controller_cu_busy;
    if (obs_start) begin start_count++; last_start_cyc = cyc; end
    if (obs_ack)   begin ack_count++;   last_ack_cyc   = cyc; end
    if (exp_valid) begin
      check_eq("start", 32'(obs_start), 32'(e_start));
      check_eq("ack", 32'(obs_ack), 32'(e_ack));
      check_eq("wg_alloc_valid", 32'(obs_com), 32'(e_com));
      check_eq("wg_rejected_valid", 32'(obs_rej), 32'(e_rej));
      check_eq("cu_busy", 32'(obs_busy), 32'(e_busy));
      if (e_com) check_eq("alloc_cu_id", 32'(obs_id), e_id);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(input int limit);
    int snap = start_count;
    int n = 0;
    while (start_count == snap && n < limit) begin run_cycle(); n++; end
    check_eq("start_seen", 32'(start_count != snap), 1);
  endtask

  task automatic wait_ack(input int limit);
    int snap = ack_count;
    int n = 0;
    while (ack_count == snap && n < limit) begin run_cycle(); n++; end
    check_eq("ack_seen", 32'(ack_count != snap), 1);
  endtask

  task automatic do_reset(input int n);
    bfm_en = 0;
    rst = 1;
    for (int i = 0; i < n; i++) begin
      bus_if.inflight_wg_buffer_alloc_valid = 1'($urandom);
      bus_if.allocator_cu_valid    = 1'($urandom);
      bus_if.allocator_cu_rejected = 1'($urandom);
      bus_if.allocator_cu_id_out   = IDW'($urandom);
      bus_if.grt_cam_up_valid      = 1'($urandom);
      bus_if.grt_cam_up_cu_id      = IDW'($urandom);
      run_cycle();
    end
    rst = 0;
    bus_if.inflight_wg_buffer_alloc_valid = 0;
    bus_if.grt_cam_up_valid = 0;
    bus_if.grt_cam_up_cu_id = '0;
    bfm_clear();
    bfm_en = 1;
    run_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, c, r, rel, sc;
    bus_if.inflight_wg_buffer_alloc_valid = 0;
    bus_if.allocator_cu_valid = 0;
    bus_if.allocator_cu_rejected = 0;
    bus_if.allocator_cu_id_out = '0;
    bus_if.grt_cam_up_valid = 0;
    bus_if.grt_cam_up_cu_id = '0;
    @(posedge clk);
    #1;

    // Reset
    do_reset(2);
    check_eq("rst_busy", 32'(obs_busy), 0);
    check_eq("rst_outs", 32'({obs_start, obs_ack, obs_com, obs_rej}), 0);

    // Single accept on CU 2, verdict two cycles after start
    bus_if.inflight_wg_buffer_alloc_valid = 1;
    f_kind = 1; f_id = 2; f_delay = 2;
    sc = start_count;
    wait_start(10);
    s = last_start_cyc;
    wait_ack(10);
    a = last_ack_cyc;
    check_eq("acc_latency", a - s, 3);
    check_eq("acc_commit", 32'(obs_com), 1);
    check_eq("acc_id", 32'(obs_id), 2);
    check_eq("acc_busy", 32'(obs_busy), 32'h4);
    check_eq("acc_one_start", start_count - sc, 1);
    f_kind = 2; f_delay = 0;
    wait_start(10);
    check_eq("acc_next_start", last_start_cyc - (a - 1), 4);
    bus_if.inflight_wg_buffer_alloc_valid = 0;
    wait_ack(10);

    // Busy release of CU 2
    bus_if.grt_cam_up_valid = 1; bus_if.grt_cam_up_cu_id = 2'd2;
    run_cycle();
    bus_if.grt_cam_up_valid = 0;
    run_cycle();
    check_eq("rel_busy", 32'(obs_busy), 0);

    // All busy
    do_reset(2);
    bus_if.inflight_wg_buffer_alloc_valid = 1;
    f_kind = 1; f_delay = -1;
    for (int i = 0; i < NCU; i++) begin
      f_id = i;
      wait_ack(20);
    end
    check_eq("full_busy", 32'(obs_busy), 32'hF);
    sc = start_count;
    repeat (50) run_cycle();
    check_eq("full_no_start", start_count - sc, 0);
    f_kind = 2;
    c = cyc;
    bus_if.grt_cam_up_valid = 1; bus_if.grt_cam_up_cu_id = 2'd1;
    run_cycle();
    bus_if.grt_cam_up_valid = 0;
    run_cycle();
    check_eq("full_release_busy", 32'(obs_busy), 32'hD);
    wait_start(5);
    check_eq("full_release_start", last_start_cyc - c, 2);
    wait_ack(10);

    // Reject and holdoff
    do_reset(2);
    bus_if.inflight_wg_buffer_alloc_valid = 1;
    f_kind = 2; f_delay = 1;
    wait_ack(10);
    r = last_ack_cyc;
    check_eq("rej_pulse", 32'({obs_com, obs_rej}), 32'b01);
    check_eq("rej_busy", 32'(obs_busy), 0);
    wait_start(40);
    check_eq("rej_holdoff", last_start_cyc - r, RD + 2);
    wait_ack(10);
    r = last_ack_cyc;
    run_cycle();
    run_cycle();
    c = cyc;
    check_eq("rej_cam_cycle", c - r, 3);
    bus_if.grt_cam_up_valid = 1; bus_if.grt_cam_up_cu_id = 2'd0;
    run_cycle();
    bus_if.grt_cam_up_valid = 0;
    wait_start(10);
    check_eq("rej_cam_start", last_start_cyc - c, 2);
    wait_ack(10);

    // Reset in the middle of a transaction
    do_reset(2);
    bus_if.inflight_wg_buffer_alloc_valid = 1;
    f_kind = 1; f_delay = -1;
    f_id = 0; wait_ack(20);
    f_id = 1; wait_ack(20);
    check_eq("mid_busy", 32'(obs_busy), 32'h3);
    f_id = 2; f_delay = 2;
    wait_start(10);
    run_cycle();
    rst = 1;
    run_cycle();
    rst = 0;
    bfm_clear();
    rel = cyc;
    run_cycle();
    check_eq("mid_no_ack", 32'(obs_ack), 0);
    check_eq("mid_busy_clr", 32'(obs_busy), 0);
    wait_start(5);
    check_eq("mid_restart", last_start_cyc - rel, 1);
    wait_ack(10);

    // Randomized traffic against the model
    do_reset(2);
    f_kind = 0; f_id = -1; f_delay = -1;
    for (int i = 0; i < 2000; i++) begin
      bus_if.inflight_wg_buffer_alloc_valid = ($urandom_range(0, 3) != 0);
      bus_if.grt_cam_up_valid = ($urandom_range(0, 7) == 0);
      bus_if.grt_cam_up_cu_id = IDW'($urandom);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
